stat_engine: RTL and testbench

Parametrised pet-statistics engine; successor to the fixed six-stat, 4-bit stats block. Holds NUM_STATS saturating counters ("need" levels: 0 = satisfied, MAX = critical). A prescaled decay tick raises one selected stat; edge-detected care buttons lower individual stats by a per-build step. Feeds the display/FSM layer with a packed stat bus plus critical flags.

---
 rtl/stat_pkg.sv | 23 ++
 rtl/stat_cell.sv | 56 +++++
 rtl/stat_engine.sv | 105 ++++++++++
 tb/tb_stat_engine.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/stat_pkg.sv
// Shared constants for the pet-statistics engine: build defaults,
// decay-target mode encodings and the indices of the six game stats.
package stat_pkg;

  localparam int DEF_NUM_STATS  = 6;
  localparam int DEF_STAT_W     = 4;
  localparam int DEF_TICK_DIV   = 1000;
  localparam int DEF_CARE_STEP  = 1;
  localparam int DEF_DECAY_STEP = 1;
  localparam int DEF_INIT_VAL   = 0;

  localparam int MODE_RANDOM = 0;
  localparam int MODE_RR     = 1;
  localparam int DEF_MODE    = MODE_RANDOM;

  localparam int HUNGER    = 0;
  localparam int HAPPINESS = 1;
  localparam int HEALTH    = 2;
  localparam int HYGIENE   = 3;
  localparam int ENERGY    = 4;
  localparam int SOCIAL    = 5;

endpackage

// File: rtl/stat_cell.sv
// One saturating need counter: adds INC_STEP on inc_en, subtracts
// DEC_STEP on dec_en, both in the same update, clamped to 0..MAX.
module stat_cell
  import stat_pkg::*;
#(
  parameter int STAT_W   = DEF_STAT_W,
  parameter int INC_STEP = DEF_DECAY_STEP,
  parameter int DEC_STEP = DEF_CARE_STEP,
  parameter int INIT_VAL = DEF_INIT_VAL
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              inc_en,
  input  logic              dec_en,
  output logic [STAT_W-1:0] value,
  output logic              at_max,
  output logic              at_max_next
);

  localparam logic [STAT_W-1:0]        MAX    = '1;
  localparam logic [STAT_W-1:0]        INIT_V = STAT_W'(INIT_VAL);
  localparam logic signed [STAT_W+1:0] MAX_S  = $signed({2'b00, MAX});
  localparam logic signed [STAT_W+1:0] INC_S  = (STAT_W+2)'(INC_STEP);
  localparam logic signed [STAT_W+1:0] DEC_S  = (STAT_W+2)'(DEC_STEP);

  logic [STAT_W-1:0]        value_q, value_d;
  logic                     at_max_q, at_max_d;
  logic signed [STAT_W+1:0] sum;

  // Net change in two extra bits (range -MAX..2*MAX) so the clamp never wraps
  always_comb begin
    sum = $signed({2'b00, value_q});
    if (inc_en) sum = sum + INC_S;
    if (dec_en) sum = sum - DEC_S;
    if (sum[STAT_W+1])    value_d = '0;
    else if (sum > MAX_S) value_d = MAX;
    else                  value_d = sum[STAT_W-1:0];
    at_max_d = (value_d == MAX);
  end

  // Counter and its max flag update together
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      value_q  <= INIT_V;
      at_max_q <= (INIT_V == MAX);
    end else begin
      value_q  <= value_d;
      at_max_q <= at_max_d;
    end
  end

  assign value       = value_q;
  assign at_max      = at_max_q;
  assign at_max_next = at_max_d;

endmodule

// File: rtl/stat_engine.sv
// Pet-statistics engine: prescaled decay tick raises one selected stat,
// rising edges on care buttons lower individual stats.
module stat_engine
  import stat_pkg::*;
#(
  parameter int NUM_STATS  = DEF_NUM_STATS,
  parameter int STAT_W     = DEF_STAT_W,
  parameter int TICK_DIV   = DEF_TICK_DIV,
  parameter int CARE_STEP  = DEF_CARE_STEP,
  parameter int DECAY_STEP = DEF_DECAY_STEP,
  parameter int MODE       = DEF_MODE,
  parameter int INIT_VAL   = DEF_INIT_VAL
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [NUM_STATS-1:0]        act,
  input  logic [7:0]                  random,
  input  logic                        pause,
  output logic [NUM_STATS*STAT_W-1:0] stats,
  output logic [NUM_STATS-1:0]        critical,
  output logic                        any_critical,
  output logic                        tick
);

  localparam int SEL_W = $clog2(NUM_STATS);
  localparam int CNT_W = $clog2(TICK_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);
  localparam logic [SEL_W-1:0] PTR_LAST = SEL_W'(NUM_STATS - 1);

  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [SEL_W-1:0]     ptr_q, ptr_d;
  logic [NUM_STATS-1:0] act_q, act_d;
  logic                 tick_q, tick_d;
  logic                 any_q, any_d;

  logic                 tick_now;
  logic [SEL_W-1:0]     target;
  logic [NUM_STATS-1:0] press;
  logic [NUM_STATS-1:0] inc_en;
  logic [NUM_STATS-1:0] crit_next;
  logic                 unused_random;

  // Only the low SEL_W bits of random select a target
  assign unused_random = ^random;

  // Prescaler, round-robin pointer, decay target and care edge detect
  always_comb begin
    tick_now = !pause && (cnt_q == CNT_LAST);
    cnt_d    = cnt_q;
    if (!pause) cnt_d = tick_now ? '0 : cnt_q + 1'b1;
    ptr_d = ptr_q;
    if (tick_now) ptr_d = (ptr_q == PTR_LAST) ? '0 : ptr_q + 1'b1;
    target = (MODE == MODE_RR) ? ptr_q : random[SEL_W-1:0];
    tick_d = tick_now;
    act_d  = act;
    press  = act & ~act_q;
    inc_en = '0;
    for (int unsigned i = 0; i < NUM_STATS; i++) begin
      inc_en[i] = tick_now && (target == SEL_W'(i));
    end
  end

  // Summary flag from next-state values so it lands with the stats
  always_comb begin
    any_d = |crit_next;
  end

  // Control state registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q  <= '0;
      ptr_q  <= '0;
      act_q  <= '0;
      tick_q <= 1'b0;
      any_q  <= (STAT_W'(INIT_VAL) == '1);
    end else begin
      cnt_q  <= cnt_d;
      ptr_q  <= ptr_d;
      act_q  <= act_d;
      tick_q <= tick_d;
      any_q  <= any_d;
    end
  end

  for (genvar g = 0; g < NUM_STATS; g++) begin : g_cell
    stat_cell #(
      .STAT_W  (STAT_W),
      .INC_STEP(DECAY_STEP),
      .DEC_STEP(CARE_STEP),
      .INIT_VAL(INIT_VAL)
    ) u_cell (
      .clk        (clk),
      .reset_n    (reset_n),
      .inc_en     (inc_en[g]),
      .dec_en     (press[g]),
      .value      (stats[g*STAT_W +: STAT_W]),
      .at_max     (critical[g]),
      .at_max_next(crit_next[g])
    );
  end

  assign tick         = tick_q;
  assign any_critical = any_q;

endmodule

// File: tb/tb_stat_engine.sv
// Scoreboard bench for stat_engine: two builds (random target / care step 1,
// round-robin / care step 5). Expected snapshots are queued per tick and a
// monitor per build pops and compares whenever tick is seen.
module tb_stat_engine;

  logic        clk = 1'b0;
  logic        rst_r_n, rst_b_n, pause_r, pause_b;
  logic [5:0]  act_r, act_b;
  logic [7:0]  rnd_r, rnd_b;
  logic [23:0] stats_r, stats_b;
  logic [5:0]  crit_r, crit_b;
  logic        anyc_r, anyc_b, tick_r, tick_b;

  typedef struct packed {
    logic [23:0] st;
    logic [5:0]  cr;
    logic        ac;
  } exp_t;

  exp_t        q_r[$];
  exp_t        q_b[$];
  int          checks = 0;
  int          errors = 0;
  logic [23:0] mr, mb;

  always #5 clk = ~clk;

  stat_engine #(
    .NUM_STATS(6), .STAT_W(4), .TICK_DIV(4), .CARE_STEP(1),
    .DECAY_STEP(1), .MODE(0), .INIT_VAL(0)
  ) u_rand (
    .clk(clk), .reset_n(rst_r_n), .act(act_r), .random(rnd_r), .pause(pause_r),
    .stats(stats_r), .critical(crit_r), .any_critical(anyc_r), .tick(tick_r)
  );

  stat_engine #(
    .NUM_STATS(6), .STAT_W(4), .TICK_DIV(4), .CARE_STEP(5),
    .DECAY_STEP(1), .MODE(1), .INIT_VAL(0)
  ) u_rr (
    .clk(clk), .reset_n(rst_b_n), .act(act_b), .random(rnd_b), .pause(pause_b),
    .stats(stats_b), .critical(crit_b), .any_critical(anyc_b), .tick(tick_b)
  );

  function automatic exp_t snap(input logic [23:0] v);
    exp_t e;
    e.st = v;
    for (int i = 0; i < 6; i++) e.cr[i] = (v[i*4 +: 4] == 4'hF);
    e.ac = |e.cr;
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic wait_tick(input bit which_b);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (((which_b ? tick_b : tick_r) !== 1'b1) && n < 50);
    if ((which_b ? tick_b : tick_r) !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL tick_timeout_%s: no tick within 50 cycles", which_b ? "rr" : "rand");
    end
  endtask

  always @(negedge clk) begin : mon_r
    exp_t e;
    if (tick_r === 1'b1) begin
      if (q_r.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rand_unexpected_tick: tick with empty scoreboard at %0t", $time);
      end else begin
        e = q_r.pop_front();
        chk("rand_stats", 32'(stats_r), 32'(e.st));
        chk("rand_crit",  32'(crit_r),  32'(e.cr));
        chk("rand_any",   32'(anyc_r),  32'(e.ac));
      end
    end
  end

  always @(negedge clk) begin : mon_b
    exp_t e;
    if (tick_b === 1'b1) begin
      if (q_b.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rr_unexpected_tick: tick with empty scoreboard at %0t", $time);
      end else begin
        e = q_b.pop_front();
        chk("rr_stats", 32'(stats_b), 32'(e.st));
        chk("rr_crit",  32'(crit_b),  32'(e.cr));
        chk("rr_any",   32'(anyc_b),  32'(e.ac));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit seen;
    rst_r_n = 1'b0; rst_b_n = 1'b0;
    pause_r = 1'b0; pause_b = 1'b0;
    act_r = '0; act_b = '0;
    rnd_r = '0; rnd_b = 8'hA5;
    mr = '0; mb = '0;
    repeat (3) @(negedge clk);

    // ---- round-robin build: reset, first tick timing, 7 ticks with wrap
    for (int k = 0; k < 7; k++) begin
      mb[(k % 6)*4 +: 4] = mb[(k % 6)*4 +: 4] + 4'd1;
      q_b.push_back(snap(mb));
    end
    rst_b_n = 1'b1;
    #1;
    chk("rr_reset_stats", 32'(stats_b), 32'h0);
    chk("rr_reset_crit",  32'(crit_b),  32'h0);
    chk("rr_reset_any",   32'(anyc_b),  32'h0);
    chk("rr_reset_tick",  32'(tick_b),  32'h0);
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      chk("rr_first_tick", 32'(tick_b), (c == 4) ? 32'h1 : 32'h0);
    end
    repeat (6) wait_tick(1'b1);

    // care step 5 on stat0 == 2 clamps to 0; next tick targets stat1
    mb[3:0] = 4'd0;
    mb[7:4] = 4'd2;
    q_b.push_back(snap(mb));
    act_b = 6'b000001;
    @(negedge clk);
    act_b = '0;
    chk("rr_care_clamp", 32'(stats_b[3:0]), 32'h0);
    wait_tick(1'b1);

    // async reset mid-count, then prescaler and pointer restart
    repeat (2) @(negedge clk);
    rst_b_n = 1'b0;
    #1;
    chk("rr_midreset_stats", 32'(stats_b), 32'h0);
    chk("rr_midreset_tick",  32'(tick_b),  32'h0);
    @(negedge clk);
    mb = '0;
    mb[3:0] = 4'd1;
    q_b.push_back(snap(mb));
    rst_b_n = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      chk("rr_restart_tick", 32'(tick_b), (c == 4) ? 32'h1 : 32'h0);
    end
    rst_b_n = 1'b0;

    // ---- random build: target stat2 three times
    rnd_r = 8'h02;
    for (int k = 1; k <= 3; k++) begin
      mr[11:8] = 4'(k);
      q_r.push_back(snap(mr));
    end
    rst_r_n = 1'b1;
    #1;
    chk("rand_reset_stats", 32'(stats_r), 32'h0);
    chk("rand_reset_crit",  32'(crit_r),  32'h0);
    repeat (3) wait_tick(1'b0);

    // out-of-range select: nothing decays
    rnd_r = 8'h07;
    q_r.push_back(snap(mr));
    wait_tick(1'b0);

    // upper random bits ignored (sel = 3); saturate stat3 and hold at 15
    rnd_r = 8'hF3;
    for (int k = 1; k <= 17; k++) begin
      mr[15:12] = (k > 15) ? 4'd15 : 4'(k);
      q_r.push_back(snap(mr));
    end
    repeat (17) wait_tick(1'b0);

    // raise stat0 to 6
    rnd_r = 8'h00;
    for (int k = 1; k <= 6; k++) begin
      mr[3:0] = 4'(k);
      q_r.push_back(snap(mr));
    end
    repeat (6) wait_tick(1'b0);

    // held button counts once; ticks during hold go nowhere
    rnd_r = 8'h07;
    act_r = 6'b000001;
    mr[3:0] = 4'd5;
    q_r.push_back(snap(mr));
    q_r.push_back(snap(mr));
    q_r.push_back(snap(mr));
    @(negedge clk);
    chk("rand_edge_once", 32'(stats_r[3:0]), 32'h5);
    repeat (9) @(negedge clk);
    act_r = '0;
    // new press lands on the same edge as a tick targeting stat0
    @(negedge clk);
    act_r = 6'b000001;
    rnd_r = 8'h00;
    wait_tick(1'b0);

    // two presses in one cycle; stat3 leaves critical
    rnd_r = 8'h07;
    act_r = 6'b001100;
    mr[11:8]  = 4'd2;
    mr[15:12] = 4'd14;
    q_r.push_back(snap(mr));
    @(negedge clk);
    act_r = '0;
    chk("rand_multi_press", 32'(stats_r), 32'(mr));
    chk("rand_multi_crit",  32'(crit_r),  32'h0);
    chk("rand_multi_any",   32'(anyc_r),  32'h0);
    wait_tick(1'b0);

    // pause: no ticks for 20 cycles, care still applies
    pause_r = 1'b1;
    seen = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (tick_r === 1'b1) seen = 1'b1;
      if (c == 5) act_r = 6'b000100;
      if (c == 6) act_r = '0;
    end
    chk("rand_pause_no_tick", 32'(seen), 32'h0);
    mr[11:8] = 4'd1;
    chk("rand_pause_care", 32'(stats_r), 32'(mr));
    q_r.push_back(snap(mr));
    pause_r = 1'b0;
    wait_tick(1'b0);

    @(negedge clk);
    chk("rand_queue_drained", 32'(q_r.size()), 32'h0);
    chk("rr_queue_drained",   32'(q_b.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
